// File: rtl/mac_layer_ctrl_if.sv
// Handshake and datapath-control bundle between a layer sequencer and its
// surroundings.
//   slave  : sequencer view (consumes x / in_valid / abort / out_ready,
//            drives in_ready, mac_* controls, out_valid, busy)
//   master : upstream/downstream/datapath view (opposite directions)
interface mac_layer_ctrl_if #(
  parameter int unsigned BITSIZE = 24,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned IDXW    = (N_IN > 1) ? $clog2(N_IN) : 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [BITSIZE*N_IN-1:0]   x;
  logic                      abort;
  logic [BITSIZE-1:0]        mac_x;
  logic [IDXW-1:0]           mac_row;
  logic                      mac_mul_en;
  logic                      mac_bias_load;
  logic                      mac_acc_en;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  modport slave (
    input  in_valid, x, abort, out_ready,
    output in_ready, mac_x, mac_row, mac_mul_en, mac_bias_load, mac_acc_en,
           out_valid, busy
  );

  modport master (
    output in_valid, x, abort, out_ready,
    input  in_ready, mac_x, mac_row, mac_mul_en, mac_bias_load, mac_acc_en,
           out_valid, busy
  );
endinterface

// File: rtl/mac_layer_ctrl.sv
// Sequencer for one time-multiplexed fully-connected layer. Captures an
// input vector, then drives the lane-parallel MAC datapath through
// bias load, N_IN multiply steps (accumulate lagging by one) and a drain
// step, and finally holds the result valid until consumed.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : handshake (in_valid/in_ready/x, out_valid/out_ready),
//                soft abort, datapath controls (mac_*), busy
module mac_layer_ctrl #(
  parameter int unsigned BITSIZE = 24,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned IDXW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  mac_layer_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t               r_state;
  logic [IDXW-1:0]      r_cnt;
  logic [BITSIZE-1:0]   r_xv [N_IN];
  logic                 r_in_ready;
  logic [BITSIZE-1:0]   r_mac_x;
  logic [IDXW-1:0]      r_mac_row;
  logic                 r_mul_en;
  logic                 r_bias_load;
  logic                 r_acc_en;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [IDXW-1:0]      w_next_cnt;

  assign w_next_cnt = r_cnt + IDXW'(1);

  // State and all outputs are registered together: each branch sets the
  // outputs that belong to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      for (int i = 0; i < int'(N_IN); i++) r_xv[i] <= '0;
      r_in_ready  <= 1'b1;
      r_mac_x     <= '0;
      r_mac_row   <= '0;
      r_mul_en    <= 1'b0;
      r_bias_load <= 1'b0;
      r_acc_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b1;
      r_mac_x     <= '0;
      r_mac_row   <= '0;
      r_mul_en    <= 1'b0;
      r_bias_load <= 1'b0;
      r_acc_en    <= 1'b0;
      r_out_valid <= 1'b0;

      // Abort outranks every other transition once a vector is in flight.
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_in_ready <= 1'b1;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.in_valid && !bus.abort) begin
              for (int i = 0; i < int'(N_IN); i++)
                r_xv[i] <= bus.x[BITSIZE*i +: BITSIZE];
              r_cnt       <= '0;
              r_bias_load <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
          S_LOAD: begin
            // First RUN step: row 0, no product registered yet to accumulate.
            r_state  <= S_RUN;
            r_mul_en <= 1'b1;
            r_mac_x  <= r_xv[0];
          end
          S_RUN: begin
            if (r_cnt == IDXW'(N_IN - 1)) begin
              r_state  <= S_DRAIN;
              r_acc_en <= 1'b1;
            end else begin
              r_cnt     <= w_next_cnt;
              r_mul_en  <= 1'b1;
              r_acc_en  <= 1'b1;
              r_mac_row <= w_next_cnt;
              r_mac_x   <= r_xv[w_next_cnt];
            end
          end
          S_DRAIN: begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end
          S_OUT: begin
            if (bus.out_ready) begin
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_out_valid <= 1'b1;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.mac_x         = r_mac_x;
  assign bus.mac_row       = r_mac_row;
  assign bus.mac_mul_en    = r_mul_en;
  assign bus.mac_bias_load = r_bias_load;
  assign bus.mac_acc_en    = r_acc_en;
  assign bus.out_valid     = r_out_valid;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_mac_layer_ctrl.sv
// Bench for mac_layer_ctrl: a cycle-schedule reference model for the
// N_IN=10 instance checked every cycle, directed scenarios with literal
// expectations, and a small N_IN=1 instance checked by hand.
module tb_mac_layer_ctrl;

  localparam int unsigned BITSIZE = 24;
  localparam int unsigned N_IN    = 10;
  localparam int unsigned IDXW    = 4;
  localparam int          NI      = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mac_layer_ctrl_if #(.BITSIZE(BITSIZE), .N_IN(N_IN), .IDXW(IDXW)) u_if ();
  mac_layer_ctrl_if #(.BITSIZE(BITSIZE), .N_IN(1), .IDXW(1))      u_if1 ();

  mac_layer_ctrl #(.BITSIZE(BITSIZE), .N_IN(N_IN), .IDXW(IDXW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  mac_layer_ctrl #(.BITSIZE(BITSIZE), .N_IN(1), .IDXW(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since the accepted handshake.
  // t=1 bias load, t=2..N+1 multiply row t-2, t=3..N+2 accumulate,
  // t>=N+3 result held until consumed; inactive means idle.
  bit                 m_active;
  int                 m_t;
  logic [BITSIZE-1:0] m_vec [NI];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      if (u_if.in_valid && !u_if.abort) begin
        m_active <= 1'b1;
        m_t      <= 1;
        for (int k = 0; k < NI; k++) m_vec[k] <= u_if.x[BITSIZE*k +: BITSIZE];
      end
    end else if (u_if.abort) begin
      m_active <= 1'b0;
    end else if (m_t >= NI + 3) begin
      if (u_if.out_ready) m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic e_mul();
    return m_active && (m_t >= 2) && (m_t <= NI + 1);
  endfunction

  function automatic logic [63:0] e_row();
    return e_mul() ? 64'(m_t - 2) : 64'd0;
  endfunction

  function automatic logic [63:0] e_x();
    return e_mul() ? 64'(m_vec[m_t - 2]) : 64'd0;
  endfunction

  always @(negedge clk) begin
    chk("m_in_ready",  64'(u_if.in_ready),      64'(!m_active));
    chk("m_busy",      64'(u_if.busy),          64'(m_active));
    chk("m_bias_load", 64'(u_if.mac_bias_load), 64'(m_active && m_t == 1));
    chk("m_mul_en",    64'(u_if.mac_mul_en),    64'(e_mul()));
    chk("m_acc_en",    64'(u_if.mac_acc_en),    64'(m_active && m_t >= 3 && m_t <= NI + 2));
    chk("m_out_valid", 64'(u_if.out_valid),     64'(m_active && m_t >= NI + 3));
    chk("m_mac_row",   64'(u_if.mac_row),       e_row());
    chk("m_mac_x",     64'(u_if.mac_x),         e_x());
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [BITSIZE*N_IN-1:0] vec;
  int acc_cnt;
  bit found;

  task automatic rand_vec();
    for (int k = 0; k < NI; k++) vec[BITSIZE*k +: BITSIZE] = BITSIZE'($urandom);
  endtask

  // Accept one vector then count accumulate pulses until back in idle.
  task automatic run_and_count(input string name);
    @(posedge clk); #1;
    rand_vec();
    u_if.x = vec; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    acc_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (u_if.mac_acc_en) acc_cnt++;
    end
    chk(name, 64'(acc_cnt), 64'd10);
  endtask

  initial begin
    reset = 1'b1;
    u_if.in_valid = 1'b0; u_if.x = '0; u_if.abort = 1'b0; u_if.out_ready = 1'b1;
    u_if1.in_valid = 1'b0; u_if1.x = '0; u_if1.abort = 1'b0; u_if1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(u_if.in_ready), 64'd1);
    chk("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rst_busy",      64'(u_if.busy), 64'd0);
    chk("rst_bias",      64'(u_if.mac_bias_load), 64'd0);
    reset = 1'b0;

    // N_IN=1 instance: bias@1, single mul@2, acc only @3, out_valid@4.
    @(posedge clk); #1;
    u_if1.x = 24'h000300; u_if1.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if1.in_valid = 1'b0; u_if1.x = 24'hFFFFFF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("n1_bias",  64'(u_if1.mac_bias_load), 64'(c == 1));
      chk("n1_mul",   64'(u_if1.mac_mul_en),    64'(c == 2));
      chk("n1_acc",   64'(u_if1.mac_acc_en),    64'(c == 3));
      chk("n1_outv",  64'(u_if1.out_valid),     64'(c == 4));
      chk("n1_inrdy", 64'(u_if1.in_ready),      64'(c == 5));
      if (c == 2) chk("n1_mac_x", 64'(u_if1.mac_x), 64'h300);
    end

    // Nominal run with x[k]=0x100*(k+1); x changes right after the handshake.
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) vec[BITSIZE*k +: BITSIZE] = BITSIZE'(32'h100 * (k + 1));
    u_if.x = vec; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    rand_vec(); u_if.x = vec;
    acc_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (u_if.mac_acc_en) acc_cnt++;
      chk("nom_bias",  64'(u_if.mac_bias_load), 64'(c == 1));
      chk("nom_acc",   64'(u_if.mac_acc_en),    64'(c >= 3 && c <= 12));
      chk("nom_outv",  64'(u_if.out_valid),     64'(c == 13));
      chk("nom_inrdy", 64'(u_if.in_ready),      64'(c == 14));
      if (c >= 2 && c <= 11) begin
        chk("nom_row", 64'(u_if.mac_row), 64'(c - 2));
        chk("nom_x",   64'(u_if.mac_x),   64'(32'h100 * (c - 1)));
      end
    end
    chk("nom_acc_pulses", 64'(acc_cnt), 64'd10);

    // Back-pressure with in_valid held high throughout.
    @(posedge clk); #1;
    rand_vec(); u_if.x = vec; u_if.in_valid = 1'b1; u_if.out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.out_valid) begin found = 1'b1; break; end
    end
    chk("bp_wait_out_valid", 64'(found), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_outv",  64'(u_if.out_valid), 64'd1);
      chk("bp_hold_inrdy", 64'(u_if.in_ready),  64'd0);
    end
    @(posedge clk); #1;
    u_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_outv", 64'(u_if.out_valid), 64'd1);
    @(negedge clk);
    chk("bp_idle_inrdy", 64'(u_if.in_ready), 64'd1);
    @(negedge clk);
    chk("bp_reaccept_bias", 64'(u_if.mac_bias_load), 64'd1);
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.in_ready) begin found = 1'b1; break; end
    end
    chk("bp_wait_idle", 64'(found), 64'd1);

    // Abort during RUN at k=4.
    @(posedge clk); #1;
    rand_vec(); u_if.x = vec; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.mac_mul_en && u_if.mac_row == 4'd4) begin found = 1'b1; break; end
    end
    chk("ab_wait_row4", 64'(found), 64'd1);
    u_if.abort = 1'b1;
    @(posedge clk); #1;
    u_if.abort = 1'b0;
    @(negedge clk);
    chk("ab_mul",  64'(u_if.mac_mul_en),    64'd0);
    chk("ab_acc",  64'(u_if.mac_acc_en),    64'd0);
    chk("ab_bias", 64'(u_if.mac_bias_load), 64'd0);
    chk("ab_busy", 64'(u_if.busy),          64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ab_no_outv", 64'(u_if.out_valid), 64'd0);
    end
    run_and_count("ab_next_acc_pulses");

    // Asynchronous reset between edges while in RUN at k=6.
    @(posedge clk); #1;
    rand_vec(); u_if.x = vec; u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.mac_mul_en && u_if.mac_row == 4'd6) begin found = 1'b1; break; end
    end
    chk("ar_wait_row6", 64'(found), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_inrdy", 64'(u_if.in_ready),      64'd1);
    chk("ar_mul",   64'(u_if.mac_mul_en),    64'd0);
    chk("ar_acc",   64'(u_if.mac_acc_en),    64'd0);
    chk("ar_row",   64'(u_if.mac_row),       64'd0);
    chk("ar_x",     64'(u_if.mac_x),         64'd0);
    chk("ar_busy",  64'(u_if.busy),          64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_and_count("ar_next_acc_pulses");

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      u_if.in_valid  = 1'($urandom_range(0, 1));
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      u_if.abort     = ($urandom_range(0, 24) == 0);
      rand_vec(); u_if.x = vec;
    end
    @(posedge clk); #1;
    u_if.in_valid = 1'b0; u_if.abort = 1'b0; u_if.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("end_idle", 64'(u_if.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
